rca_seq_ctrl: RTL and testbench
===============================

# rca_seq_ctrl

Sequencing controller that time-multiplexes one 8-bit ripple-carry adder core to add (or optionally subtract) multi-byte operands. It processes one byte per clock, LSB first, and chains the carry through a register between bytes. It accepts a whole operand pair over a valid/ready handshake and returns the full-width result over a second valid/ready handshake. It is the multi-precision front end for the existing 8-bit adder datapath.

## Interface
- WORDS, default 4: number of 8-bit bytes per operand; operand width W = 8*WORDS; legal range 1..16.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry into byte 0.
- op  input  1  only when RCA_SUB_EN is defined; 0 = add, 1 = subtract (A − B).
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts result.
- sum  output  W  result.
- cout  output  1  carry out of the top byte.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid && in_ready: capture a, b, cin (and op) into internal registers, clear the byte index to 0, and go to RUN.
  - in_valid while not in IDLE is ignored. No queueing.
- RUN, one byte per edge:
  - Byte i of sum = a[i] + b'[i] + carry_reg, through the core.
  - carry_reg ← core carry-out; index increments.
  - After byte WORDS−1 is written: go to DONE and set cout to the final carry.
- DONE:
  - out_valid = 1; sum and cout held stable.
  - On an edge with out_valid && out_ready: go to IDLE.
  - in_ready rises in the following cycle. There is no same-edge re-accept.
- Arithmetic:
  - Unsigned, modulo 2^W.
  - Add: b' = b, initial carry = cin.
  - Subtract: b' = ~b, initial carry = 1, cin ignored; cout = 1 means no borrow (A ≥ B).
- Inputs a, b, cin and op are sampled only on the accepting edge; changes during RUN or DONE have no effect.
- Reset (asynchronous, any state, including mid-RUN):
  - state → IDLE; the transaction is dropped.
  - sum = 0, cout = 0, out_valid = 0, busy = 0, in_ready = 1, carry_reg = 0, index = 0.

## Timing
- Latency: out_valid rises exactly WORDS edges after the accepting edge.
  - WORDS = 1 gives 1-edge latency.
- Throughput: at most one transaction per WORDS + 2 cycles when out_ready is held high.
- in_ready, out_valid and busy are decoded from registered state only; there is no combinational path from in_valid or out_ready.
- Core path: one 8-bit ripple per cycle. The full W-bit ripple never appears in one cycle.
- While out_ready is low, sum and cout stay stable indefinitely.

## Configuration
- RCA_SUB_EN defined:
  - op port exists.
  - Operand B is bitwise-inverted at the core input.
  - Initial carry is forced to 1 when op = 1.
- RCA_SUB_EN undefined:
  - No op port and no inverter logic.
  - The block is add-only with initial carry = cin.

## Structure
- Package rca_seq_pkg holds:
  - BYTE_W = 8.
  - State enum type (IDLE, RUN, DONE).
  - Index width function clog2(WORDS), minimum 1.
- Sub-module rca8_core: purely combinational 8-bit ripple adder built from eight full-adder cells, ports x, y, ci, s, co.
  - Exactly one instance.
  - The controller owns all registers.

## Test plan
1. WORDS=4, a=0x000000FF, b=0x00000001, cin=0 -> sum=0x00000100, cout=0, out_valid exactly 4 edges after accept.
2. a=0xFFFFFFFF, b=0x00000000, cin=1 -> carry ripples through all bytes: sum=0x00000000, cout=1.
3. Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> sum and cout stable, in_ready=0, busy=1, a second in_valid pulse ignored; release out_ready -> IDLE next edge, then in_ready=1.
4. With RCA_SUB_EN:
   - a=0x00000005, b=0x00000007, op=1 -> sum=0xFFFFFFFE, cout=0.
   - a=0x00000007, b=0x00000005, op=1 -> sum=0x00000002, cout=1.
5. Assert rst_n low after 2 RUN edges -> outputs immediately 0, in_ready=1. A subsequent add 0x12345678 + 0x11111111 -> sum=0x23456789, cout=0.
6. WORDS=1 build, a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, out_valid 1 edge after accept.

Source files
------------

// File: rtl/rca_seq_pkg.sv
// Shared constants, state type and index-width helper for the multi-byte
// ripple-carry sequencer.
package rca_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the byte index; never narrower than one bit so WORDS=1 still builds.
  function automatic int idx_w(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/rca8_core.sv
// Purely combinational 8-bit ripple-carry adder: eight chained full-adder cells.
module rca8_core
  import rca_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] x,
  input  logic [BYTE_W-1:0] y,
  input  logic              ci,
  output logic [BYTE_W-1:0] s,
  output logic              co
);

  logic [BYTE_W:0] c;

  assign c[0] = ci;

  generate
    for (genvar gi = 0; gi < BYTE_W; gi++) begin : g_fa
      assign s[gi]   = x[gi] ^ y[gi] ^ c[gi];
      assign c[gi+1] = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
    end
  endgenerate

  assign co = c[BYTE_W];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Multi-precision add front end: one byte per clock through a single rca8_core,
// LSB first. Define RCA_SUB_EN to add the op port and A-B subtraction.
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BYTE_W*WORDS-1:0] a,
  input  logic [BYTE_W*WORDS-1:0] b,
  input  logic                  cin,
`ifdef RCA_SUB_EN
  input  logic                  op,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BYTE_W*WORDS-1:0] sum,
  output logic                  cout,
  output logic                  busy
);

  localparam int W     = BYTE_W * WORDS;
  localparam int IDX_W = idx_w(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e            state_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      sum_q;
  logic              carry_q;
  logic              cout_q;
  logic [IDX_W-1:0]  idx_q;
  logic              carry_init_d;

  logic [BYTE_W-1:0] core_x;
  logic [BYTE_W-1:0] core_y;
  logic [BYTE_W-1:0] core_s;
  logic              core_co;

  assign core_x = a_q[idx_q*BYTE_W +: BYTE_W];

`ifdef RCA_SUB_EN
  logic sub_q;
  // Two's-complement subtract: invert B at the core and seed the carry with 1.
  assign core_y       = b_q[idx_q*BYTE_W +: BYTE_W] ^ {BYTE_W{sub_q}};
  assign carry_init_d = op ? 1'b1 : cin;
`else
  assign core_y       = b_q[idx_q*BYTE_W +: BYTE_W];
  assign carry_init_d = cin;
`endif

  rca8_core u_core (
    .x  (core_x),
    .y  (core_y),
    .ci (carry_q),
    .s  (core_s),
    .co (core_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef RCA_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= carry_init_d;
            idx_q   <= '0;
`ifdef RCA_SUB_EN
            sub_q   <= op;
`endif
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[idx_q*BYTE_W +: BYTE_W] <= core_s;
          carry_q <= core_co;
          if (idx_q == LAST_IDX) begin
            cout_q  <= core_co;
            idx_q   <= '0;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake flags depend only on the registered state.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed self-checking bench: a WORDS=4 instance and a WORDS=1 instance.
module tb_rca_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, cin, op, out_valid, out_ready, cout, busy;
  logic [31:0] a, b, sum;

  logic        in_valid1, in_ready1, cin1, op1, out_valid1, out_ready1, cout1, busy1;
  logic [7:0]  a1, b1, sum1;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rca_seq_ctrl #(.WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef RCA_SUB_EN
    .op(op),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  rca_seq_ctrl #(.WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
`ifdef RCA_SUB_EN
    .op(op1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction on the WORDS=4 instance; optional 5-cycle back-pressure.
  task automatic do_txn(input logic [31:0] ta, input logic [31:0] tb_v, input logic tcin,
                        input logic top, input logic [31:0] esum, input logic ecout,
                        input string tag, input bit hold);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    a = ta; b = tb_v; cin = tcin; op = top; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb_v; cin = ~tcin; op = ~top;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    check({tag, "_latency"}, n, 4);
    check({tag, "_sum"}, sum, esum);
    check({tag, "_cout"}, cout, ecout);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_in_ready_done"}, in_ready, 0);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        in_valid = (i == 2);
        a = 32'hA5A5A5A5; b = 32'h5A5A5A5A;
        @(posedge clk); #1;
        check({tag, "_hold_sum"}, sum, esum);
        check({tag, "_hold_cout"}, cout, ecout);
        check({tag, "_hold_valid"}, out_valid, 1);
        check({tag, "_hold_busy"}, busy, 1);
        check({tag, "_hold_in_ready"}, in_ready, 0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_in_ready_back"}, in_ready, 1);
    check({tag, "_busy_drop"}, busy, 0);
    $display("txn %s a=%08h b=%08h cin=%0d op=%0d sum=%08h cout=%0d", tag, ta, tb_v, tcin, top, sum, cout);
  endtask

  task automatic do_txn1(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                         input logic [7:0] esum, input logic ecout, input string tag);
    int n;
    @(negedge clk);
    a1 = ta; b1 = tb_v; cin1 = tcin; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    a1 = 8'h00; b1 = 8'h00; cin1 = 1'b0;
    n = 0;
    while (!out_valid1 && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_latency"}, n, 1);
    check({tag, "_sum"}, sum1, esum);
    check({tag, "_cout"}, cout1, ecout);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check({tag, "_in_ready_back"}, in_ready1, 1);
    $display("txn %s a=%02h b=%02h cin=%0d op=%0d sum=%02h cout=%0d", tag, ta, tb_v, tcin, op1, sum1, cout1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 0; a = 0; b = 0; cin = 0; op = 0; out_ready = 0;
    in_valid1 = 0; a1 = 0; b1 = 0; cin1 = 0; op1 = 0; out_ready1 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_in_ready1", in_ready1, 1);
    @(negedge clk);
    rst_n = 1'b1;

    do_txn(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, "byte_carry", 1'b0);
    do_txn(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, "full_ripple", 1'b0);
    do_txn(32'hDEADBEEF, 32'h01234567, 1'b1, 1'b0, 32'hDFD10457, 1'b0, "mixed_cin", 1'b1);
    do_txn(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, "top_overflow", 1'b0);
`ifdef RCA_SUB_EN
    do_txn(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, "sub_borrow", 1'b0);
    do_txn(32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, "sub_noborrow", 1'b0);
`endif

    // Reset in the middle of RUN drops the transaction.
    @(negedge clk);
    a = 32'h0F0F0F0F; b = 32'h01010101; cin = 1'b0; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrun_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_sum", sum, 0);
    check("midrun_rst_cout", cout, 0);
    check("midrun_rst_valid", out_valid, 0);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_in_ready", in_ready, 1);
    $display("txn midrun_reset sum=%08h cout=%0d in_ready=%0d", sum, cout, in_ready);
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, "post_reset", 1'b0);

    do_txn1(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "w1_overflow");
    do_txn1(8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, "w1_cin");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
